tpu_tile_engine: RTL and testbench

Parametrised NxN output-stationary matrix-multiply tile, the successor to the fixed 4x4 TPU top. It computes C = A x W for a runtime inner dimension K up to MAX_K. Operands load through a valid/ready port into per-lane scratch registers. Results stream out through a valid/ready port in row-major order. It sits between the host/UART loader and the board debug/LED logic.

---
 rtl/tpu_pkg.sv | 24 ++
 rtl/tpu_pe.sv | 56 +++++
 rtl/tpu_tile_engine.sv | 216 +++++++++++++++++++++
 tb/tb_tpu_tile_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and width helpers for the matrix-multiply tile and its processing elements.
// Holds no state and adds no latency.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        COMPUTE = 2'd2,
        STREAM  = 2'd3
    } state_e;

    localparam logic LD_SEL_ACT = 1'b0;
    localparam logic LD_SEL_WGT = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The feed counter runs to K+2*SIZE-2, so it needs room for MAX_K+2*SIZE values.
    function automatic int feed_cnt_w(input int max_k, input int size);
        return idx_w(max_k + 2 * size);
    endfunction

endpackage

// File: rtl/tpu_pe.sv
// Output-stationary MAC cell: one-cycle registered a/w pass-through, accumulator updates when en is high.
// No backpressure; the cell holds all of its state whenever en and clr are both low.
module tpu_pe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] w_in,
    output logic signed [DATA_WIDTH-1:0] a_out,
    output logic signed [DATA_WIDTH-1:0] w_out,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    logic signed [DATA_WIDTH-1:0]   a_q, a_d;
    logic signed [DATA_WIDTH-1:0]   w_q, w_d;
    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic signed [2*DATA_WIDTH-1:0] prod;

    always_comb begin
        prod  = a_in * w_in;
        a_d   = a_q;
        w_d   = w_q;
        acc_d = acc_q;
        if (clr) begin
            a_d   = '0;
            w_d   = '0;
            acc_d = '0;
        end else if (en) begin
            a_d   = a_in;
            w_d   = w_in;
            // The signed cast sign-extends the product; the sum wraps modulo 2^ACC_WIDTH.
            acc_d = acc_q + ACC_WIDTH'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            w_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            w_q   <= w_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign w_out = w_q;
    assign acc   = acc_q;

endmodule

// File: rtl/tpu_tile_engine.sv
// NxN output-stationary C = A x W tile; first result appears K+2*SIZE+1 cycles after an accepted start.
// Operands load only in IDLE; results stream row-major and hold while res_ready is low.
module tpu_tile_engine
    import tpu_pkg::*;
#(
    parameter int  SIZE       = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  ACC_WIDTH  = 32,
    parameter int  MAX_K      = 16,
    localparam int KW         = $clog2(MAX_K + 1),
    localparam int AW         = $clog2(MAX_K),
    localparam int LW         = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [KW-1:0]         cfg_k,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic                  ld_sel,
    input  logic [LW-1:0]         ld_lane,
    input  logic [AW-1:0]         ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic [LW-1:0]         res_row,
    output logic [LW-1:0]         res_col,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           led
);

    localparam int TW = feed_cnt_w(MAX_K, SIZE);

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [TW-1:0]   t_q, t_d;
    logic [LW-1:0]   row_q, row_d;
    logic [LW-1:0]   col_q, col_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            err_sticky_q, err_sticky_d;
    logic            pe_clr, pe_en;
    logic            cfg_ok, ld_fire, ld_in_range, at_last;
    int              feed_idx;

    logic signed [DATA_WIDTH-1:0] act_mem [SIZE][MAX_K];
    logic signed [DATA_WIDTH-1:0] wgt_mem [SIZE][MAX_K];
    logic signed [DATA_WIDTH-1:0] a_feed  [SIZE];
    logic signed [DATA_WIDTH-1:0] w_feed  [SIZE];
    logic signed [DATA_WIDTH-1:0] a_pipe  [SIZE][SIZE];
    logic signed [DATA_WIDTH-1:0] w_pipe  [SIZE][SIZE];
    logic signed [ACC_WIDTH-1:0]  acc_arr [SIZE][SIZE];

    assign cfg_ok      = (cfg_k != '0) && (int'(cfg_k) <= MAX_K);
    assign ld_fire     = ld_valid && ld_ready;
    assign ld_in_range = (int'(ld_lane) < SIZE) && (int'(ld_addr) < MAX_K);
    assign at_last     = (row_q == LW'(SIZE - 1)) && (col_q == LW'(SIZE - 1));

    // Scratch is deliberately outside reset so operands survive an aborted run.
    always_ff @(posedge clk) begin
        if (ld_fire && ld_in_range) begin
            if (ld_sel == LD_SEL_ACT) begin
                act_mem[ld_lane][ld_addr] <= ld_data;
            end else if (ld_sel == LD_SEL_WGT) begin
                wgt_mem[ld_lane][ld_addr] <= ld_data;
            end
        end
    end

    // Skew feeder: lane i sees element k = t - i, so row r and column c meet at PE(r,c) with matching k.
    always_comb begin
        feed_idx = 0;
        for (int i = 0; i < SIZE; i++) begin
            a_feed[i] = '0;
            w_feed[i] = '0;
            feed_idx  = int'(t_q) - i;
            if (feed_idx >= 0 && feed_idx < int'(k_q)) begin
                a_feed[i] = act_mem[i][feed_idx[AW-1:0]];
                w_feed[i] = wgt_mem[i][feed_idx[AW-1:0]];
            end
        end
    end

    for (genvar gr = 0; gr < SIZE; gr++) begin : g_row
        for (genvar gc = 0; gc < SIZE; gc++) begin : g_col
            logic signed [DATA_WIDTH-1:0] a_src, w_src;
            if (gc == 0) begin : g_a_edge
                assign a_src = a_feed[gr];
            end else begin : g_a_inner
                assign a_src = a_pipe[gr][gc-1];
            end
            if (gr == 0) begin : g_w_edge
                assign w_src = w_feed[gc];
            end else begin : g_w_inner
                assign w_src = w_pipe[gr-1][gc];
            end
            tpu_pe #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH)
            ) u_pe (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (pe_clr),
                .en   (pe_en),
                .a_in (a_src),
                .w_in (w_src),
                .a_out(a_pipe[gr][gc]),
                .w_out(w_pipe[gr][gc]),
                .acc  (acc_arr[gr][gc])
            );
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        t_d          = t_q;
        row_d        = row_q;
        col_d        = col_q;
        cnt_d        = (state_q != IDLE) ? cnt_q + 8'd1 : cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        pe_clr       = 1'b0;
        pe_en        = 1'b0;
        ld_ready     = 1'b0;
        res_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                ld_ready = 1'b1;
                if (start) begin
                    if (cfg_ok) begin
                        k_d          = cfg_k;
                        cnt_d        = '0;
                        err_sticky_d = 1'b0;
                        state_d      = CLEAR;
                    end else begin
                        err_d        = 1'b1;
                        err_sticky_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                pe_clr  = 1'b1;
                t_d     = '0;
                row_d   = '0;
                col_d   = '0;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                pe_en = 1'b1;
                if (int'(t_q) == int'(k_q) + 2 * SIZE - 2) begin
                    state_d = STREAM;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            STREAM: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (col_q == LW'(SIZE - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            k_q          <= '0;
            t_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            t_q          <= t_d;
            row_q        <= row_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign res_data = acc_arr[row_q][col_q];
    assign res_row  = row_q;
    assign res_col  = col_q;
    assign res_last = res_valid && at_last;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign led      = {cnt_q, 1'b0, 1'b0, state_q, err_sticky_q, res_valid, done_q, busy};

endmodule

// File: tb/tb_tpu_tile_engine.sv
// Directed bench for tpu_tile_engine: loads operands, runs tiles, and checks every streamed element
// against a software matrix product, plus latency, backpressure, rejected starts and reset abort.
module tb_tpu_tile_engine;

    localparam int SIZE  = 4;
    localparam int MAX_K = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  cfg_k;
    logic        ld_valid;
    logic        ld_ready;
    logic        ld_sel;
    logic [1:0]  ld_lane;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_row;
    logic [1:0]  res_col;
    logic        res_last;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] led;

    int n_assert = 0;
    int n_fail   = 0;
    int a_m [SIZE][MAX_K];
    int w_m [MAX_K][SIZE];
    int c_exp [SIZE][SIZE];

    always #5 clk = ~clk;

    tpu_tile_engine dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_k    (cfg_k),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_sel   (ld_sel),
        .ld_lane  (ld_lane),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_row  (res_row),
        .res_col  (res_col),
        .res_last (res_last),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .led      (led)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input int lane, input int addr, input int data);
        logic [31:0] l, a, d;
        l = lane; a = addr; d = data;
        ld_valid = 1'b1;
        ld_sel   = sel;
        ld_lane  = l[1:0];
        ld_addr  = a[3:0];
        ld_data  = d[7:0];
        chk("ld_ready_idle", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        if (sel) w_m[addr][lane] = data;
        else     a_m[lane][addr] = data;
    endtask

    task automatic load_identity_set();
        for (int r = 0; r < SIZE; r++)
            for (int k = 0; k < 4; k++)
                load(1'b0, r, k, (r == k) ? 1 : 0);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < SIZE; c++)
                load(1'b1, c, k, 4 * k + c + 1);
    endtask

    task automatic calc_exp(input int k);
        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                c_exp[r][c] = 0;
                for (int kk = 0; kk < k; kk++)
                    c_exp[r][c] += a_m[r][kk] * w_m[kk][c];
            end
    endtask

    // mode 0: res_ready always high; mode 1: 5-cycle stall at element 5, then toggle every cycle.
    task automatic collect(input int mode);
        int idx, stall, cyc;
        logic rdy;
        idx = 0; stall = 0; cyc = 0; rdy = 1'b1;
        while (idx < SIZE * SIZE && cyc < 500) begin
            if (mode == 1 && idx == 5 && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end else if (mode == 1 && stall >= 5) begin
                rdy = ~rdy;
            end else begin
                rdy = 1'b1;
            end
            res_ready = rdy;
            chk("res_valid", res_valid, 1);
            chk("busy_stream", busy, 1);
            chk("res_data", $signed(res_data), c_exp[idx / SIZE][idx % SIZE]);
            chk("res_row", res_row, idx / SIZE);
            chk("res_col", res_col, idx % SIZE);
            chk("res_last", res_last, (idx == SIZE * SIZE - 1) ? 1 : 0);
            if (rdy) idx++;
            tick();
            cyc++;
        end
        res_ready = 1'b1;
        chk("stream_timeout", (cyc < 500) ? 1 : 0, 1);
        chk("done_pulse", done, 1);
        chk("res_valid_after", res_valid, 0);
        chk("busy_after", busy, 0);
        tick();
        chk("done_one_cycle", done, 0);
    endtask

    // Optional write in the start cycle; optional intrusion (write + start) while busy at cycle intrude_at.
    task automatic run(input int k, input bit wr, input logic wsel, input int wlane, input int waddr,
                       input int wdata, input int intrude_at, input int mode);
        int n;
        logic [31:0] kv, l, a, d;
        kv = k; l = wlane; a = waddr; d = wdata;
        start = 1'b1;
        cfg_k = kv[4:0];
        if (wr) begin
            ld_valid = 1'b1;
            ld_sel   = wsel;
            ld_lane  = l[1:0];
            ld_addr  = a[3:0];
            ld_data  = d[7:0];
            chk("ld_ready_start", ld_ready, 1);
        end
        tick();
        start    = 1'b0;
        ld_valid = 1'b0;
        if (wr) begin
            if (wsel) w_m[waddr][wlane] = wdata;
            else      a_m[wlane][waddr] = wdata;
        end
        calc_exp(k);
        chk("busy_clear", busy, 1);
        chk("led_state_clear", led[6:4], 1);
        chk("led_sticky_cleared", led[3], 0);
        n = 1;
        while (res_valid !== 1'b1 && n < 300) begin
            if (n == intrude_at) begin
                ld_valid = 1'b1;
                ld_sel   = 1'b0;
                ld_lane  = 2'd0;
                ld_addr  = 4'd0;
                ld_data  = 8'd99;
                start    = 1'b1;
                cfg_k    = kv[4:0];
                chk("ld_ready_busy", ld_ready, 0);
                chk("busy_compute", busy, 1);
            end
            tick();
            ld_valid = 1'b0;
            start    = 1'b0;
            n++;
        end
        chk("first_valid_latency", n, k + 2 * SIZE + 1);
        chk("led_cycle_count", led[15:8], n - 1);
        chk("led_state_stream", led[6:4], 3);
        collect(mode);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; cfg_k = '0; ld_valid = 1'b0; ld_sel = 1'b0;
        ld_lane = '0; ld_addr = '0; ld_data = '0; res_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_led", led, 0);
        chk("rst_res_data", res_data, 0);
        rst_n = 1'b1;
        tick();

        // Identity A with ramp W: results 1..16, latency 13.
        load_identity_set();
        run(4, 1'b0, 1'b0, 0, 0, 0, -1, 0);

        // Signed extremes over the full depth.
        for (int r = 0; r < SIZE; r++)
            for (int k = 0; k < MAX_K; k++) begin
                load(1'b0, r, k, -128);
                load(1'b1, r, k, -128);
            end
        run(16, 1'b0, 1'b0, 0, 0, 0, -1, 0);
        for (int c = 0; c < SIZE; c++)
            for (int k = 0; k < MAX_K; k++)
                load(1'b1, c, k, 127);
        run(16, 1'b0, 1'b0, 0, 0, 0, -1, 0);

        // Backpressure.
        load_identity_set();
        run(4, 1'b0, 1'b0, 0, 0, 0, -1, 1);

        // Rejected starts.
        cfg_k = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_k0", err, 1);
        chk("busy_k0", busy, 0);
        chk("sticky_k0", led[3], 1);
        tick();
        chk("err_k0_pulse", err, 0);
        chk("sticky_k0_hold", led[3], 1);
        cfg_k = 5'd17; start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_k17", err, 1);
        chk("busy_k17", busy, 0);
        tick();
        chk("err_k17_pulse", err, 0);
        chk("sticky_k17_hold", led[3], 1);

        // Busy protection at K=1, then write coincident with start.
        for (int r = 0; r < SIZE; r++) load(1'b0, r, 0, r + 1);
        for (int c = 0; c < SIZE; c++) load(1'b1, c, 0, c + 2);
        run(1, 1'b0, 1'b0, 0, 0, 0, 3, 0);
        run(1, 1'b1, 1'b0, 1, 0, -7, -1, 0);

        // Reset during COMPUTE, then rerun from retained scratch.
        cfg_k = 5'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre_rst_state_compute", led[6:4], 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_led", led, 0);
        done_seen = 0;
        repeat (30) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        chk("abort_no_done", done_seen, 0);
        run(4, 1'b0, 1'b0, 0, 0, 0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
